// File: rtl/projectile_move_ctrl.sv
// projectile_move_ctrl
// Producer side of the projectile position/hit interface. It launches the
// projectile from the player's position and moves it upward one step per
// video frame. Collisions reported during the frame are accumulated, and the
// hit is confirmed on the next startOfFrame. After a hit or a miss, the block
// waits out a cooldown of whole frames before it accepts another launch.
// Optional build macro: PROJECTILE_AUTOFIRE_EN. When it is defined, IDLE
// launches on the fire level rather than on the rising edge of fire.
module projectile_move_ctrl #(
  parameter int OBJECT_HEIGHT   = 32,
  parameter int X_OFFSET        = 16,
  parameter int SPEED_Y         = 8,
  parameter int TOP_LIMIT_Y     = 0,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] playerTopLeftX,
  input  logic [10:0] playerTopLeftY,
  input  logic        collision,
  input  logic [3:0]  HitEdgeCode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        projectileVisible,
  output logic        hitPulse,
  output logic [3:0]  hitEdges
);

  localparam logic [10:0] X_OFFSET_11 = 11'(X_OFFSET);
  localparam logic [10:0] HEIGHT_11   = 11'(OBJECT_HEIGHT);
  localparam logic [10:0] SPEED_11    = 11'(SPEED_Y);
  localparam logic [11:0] LIMIT_12    = 12'(TOP_LIMIT_Y + SPEED_Y);
  localparam logic [3:0]  CD_INIT     = 4'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLYING   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        fire_d_r;
  logic [10:0] top_x_r, top_x_s;
  logic [10:0] top_y_r, top_y_s;
  logic        visible_r, visible_s;
  logic        hit_pulse_r, hit_pulse_s;
  logic [3:0]  hit_edges_r, hit_edges_s;
  logic        coll_latch_r, coll_latch_s;
  logic [3:0]  edge_latch_r, edge_latch_s;
  logic [3:0]  cd_cnt_r, cd_cnt_s;

  logic        fire_edge_s;
  logic        launch_s;
  logic        hit_now_s;
  logic        coll_any_s;
  logic [3:0]  edge_any_s;
  logic        at_top_s;
  logic        cd_last_s;
  logic [10:0] launch_y_s;

  assign fire_edge_s = fire & ~fire_d_r;

`ifdef PROJECTILE_AUTOFIRE_EN
  assign launch_s = fire;
`else
  assign launch_s = fire_edge_s;
`endif

  // A collision that carries no edge code says nothing useful, so it is dropped.
  assign hit_now_s  = collision & (HitEdgeCode != 4'd0);
  assign coll_any_s = coll_latch_r | hit_now_s;
  assign edge_any_s = edge_latch_r | (hit_now_s ? HitEdgeCode : 4'd0);
  // The compare is done in 12 bits so that TOP_LIMIT_Y + SPEED_Y cannot wrap.
  assign at_top_s   = ({1'b0, top_y_r} < LIMIT_12);
  assign cd_last_s  = (cd_cnt_r <= 4'd1);
  assign launch_y_s = (playerTopLeftY < HEIGHT_11) ? 11'd0 : (playerTopLeftY - HEIGHT_11);

  // Register the FSM state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Select the next state from launch, frame boundaries, hits and the cooldown count.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_s = ST_FLYING;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FLYING: begin
        if (startOfFrame && (coll_any_s || at_top_s)) begin
          state_s = ST_COOLDOWN;
        end else begin
          state_s = ST_FLYING;
        end
      end
      ST_COOLDOWN: begin
        if (startOfFrame && cd_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_COOLDOWN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Compute the next values of the position, the hit outputs, the latches and the cooldown counter.
  always_comb begin
    top_x_s      = top_x_r;
    top_y_s      = top_y_r;
    hit_pulse_s  = 1'b0;
    hit_edges_s  = hit_edges_r;
    coll_latch_s = coll_latch_r;
    edge_latch_s = edge_latch_r;
    cd_cnt_s     = cd_cnt_r;
    visible_s    = (state_s == ST_FLYING);
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          top_x_s      = playerTopLeftX + X_OFFSET_11;
          top_y_s      = launch_y_s;
          coll_latch_s = 1'b0;
          edge_latch_s = 4'd0;
        end else begin
          top_x_s = top_x_r;
        end
      end
      ST_FLYING: begin
        if (startOfFrame) begin
          coll_latch_s = 1'b0;
          edge_latch_s = 4'd0;
          if (coll_any_s) begin
            hit_pulse_s = 1'b1;
            hit_edges_s = edge_any_s;
            cd_cnt_s    = CD_INIT;
          end else if (at_top_s) begin
            cd_cnt_s = CD_INIT;
          end else begin
            top_y_s = top_y_r - SPEED_11;
          end
        end else begin
          coll_latch_s = coll_any_s;
          edge_latch_s = edge_any_s;
        end
      end
      ST_COOLDOWN: begin
        if (startOfFrame) begin
          if (cd_last_s) begin
            cd_cnt_s = 4'd0;
          end else begin
            cd_cnt_s = cd_cnt_r - 4'd1;
          end
        end else begin
          cd_cnt_s = cd_cnt_r;
        end
      end
      default: begin
        coll_latch_s = 1'b0;
        edge_latch_s = 4'd0;
        cd_cnt_s     = 4'd0;
      end
    endcase
  end

  // Register the datapath and the outputs. fire_d tracks fire in every state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_d_r     <= 1'b0;
      top_x_r      <= 11'd0;
      top_y_r      <= 11'd0;
      visible_r    <= 1'b0;
      hit_pulse_r  <= 1'b0;
      hit_edges_r  <= 4'd0;
      coll_latch_r <= 1'b0;
      edge_latch_r <= 4'd0;
      cd_cnt_r     <= 4'd0;
    end else begin
      fire_d_r     <= fire;
      top_x_r      <= top_x_s;
      top_y_r      <= top_y_s;
      visible_r    <= visible_s;
      hit_pulse_r  <= hit_pulse_s;
      hit_edges_r  <= hit_edges_s;
      coll_latch_r <= coll_latch_s;
      edge_latch_r <= edge_latch_s;
      cd_cnt_r     <= cd_cnt_s;
    end
  end

  assign topLeftX          = top_x_r;
  assign topLeftY          = top_y_r;
  assign projectileVisible = visible_r;
  assign hitPulse          = hit_pulse_r;
  assign hitEdges          = hit_edges_r;

endmodule

// File: tb/tb_projectile_move_ctrl.sv
// Bench for projectile_move_ctrl. The stimulus pushes hand-computed expected
// output snapshots, each tagged with the negedge on which it applies, and a
// monitor pops and compares them when that negedge arrives.
module tb_projectile_move_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        fire;
  logic [10:0] playerTopLeftX;
  logic [10:0] playerTopLeftY;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        projectileVisible;
  logic        hitPulse;
  logic [3:0]  hitEdges;

  projectile_move_ctrl dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .fire              (fire),
    .playerTopLeftX    (playerTopLeftX),
    .playerTopLeftY    (playerTopLeftY),
    .collision         (collision),
    .HitEdgeCode       (HitEdgeCode),
    .topLeftX          (topLeftX),
    .topLeftY          (topLeftY),
    .projectileVisible (projectileVisible),
    .hitPulse          (hitPulse),
    .hitEdges          (hitEdges)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          stamp;
    logic [10:0] x;
    logic [10:0] y;
    logic        vis;
    logic        hp;
    logic [3:0]  edges;
  } exp_t;

  exp_t q[$];
  int   ncyc   = 0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: on each negedge, compare the DUT outputs with every snapshot due on that edge.
  always @(negedge clk) begin
    exp_t e;
    ncyc = ncyc + 1;
    while (q.size() > 0 && q[0].stamp <= ncyc) begin
      e = q.pop_front();
      checks = checks + 1;
      if (topLeftX !== e.x || topLeftY !== e.y || projectileVisible !== e.vis ||
          hitPulse !== e.hp || hitEdges !== e.edges) begin
        errors = errors + 1;
        $display("FAIL %s: got x=%0d y=%0d vis=%0b hit=%0b edges=%h, expected x=%0d y=%0d vis=%0b hit=%0b edges=%h",
                 e.nm, topLeftX, topLeftY, projectileVisible, hitPulse, hitEdges,
                 e.x, e.y, e.vis, e.hp, e.edges);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect the outputs as they are after the posedge that has just passed.
  task automatic expect_o(input string nm, input logic [10:0] x, input logic [10:0] y,
                          input logic vis, input logic hp, input logic [3:0] edges);
    exp_t t;
    t.nm = nm; t.stamp = ncyc + 1; t.x = x; t.y = y;
    t.vis = vis; t.hp = hp; t.edges = edges;
    q.push_back(t);
  endtask

  // A one-cycle startOfFrame pulse followed by one quiet cycle.
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic held_vis;
`ifdef PROJECTILE_AUTOFIRE_EN
    held_vis = 1'b1;
`else
    held_vis = 1'b0;
`endif
    resetN = 1'b0; startOfFrame = 1'b0; fire = 1'b0;
    playerTopLeftX = 11'd100; playerTopLeftY = 11'd400;
    collision = 1'b0; HitEdgeCode = 4'd0;
    tick(); tick();
    expect_o("reset", 11'd0, 11'd0, 1'b0, 1'b0, 4'h0);
    resetN = 1'b1;
    tick();

    // Launch
    fire = 1'b1; tick(); fire = 1'b0;
    expect_o("launch", 11'd116, 11'd368, 1'b1, 1'b0, 4'h0);

    // Motion: the position changes only in the cycle after each startOfFrame pulse
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("move1", 11'd116, 11'd360, 1'b1, 1'b0, 4'h0);
    tick();
    expect_o("hold_midframe", 11'd116, 11'd360, 1'b1, 1'b0, 4'h0);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("move2", 11'd116, 11'd352, 1'b1, 1'b0, 4'h0);
    tick();
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("move3", 11'd116, 11'd344, 1'b1, 1'b0, 4'h0);

    // Hit: two edge codes reported mid-frame are accumulated until the frame boundary
    collision = 1'b1; HitEdgeCode = 4'h4; tick();
    HitEdgeCode = 4'h8; tick();
    collision = 1'b0; HitEdgeCode = 4'h0; tick();
    expect_o("hit_pending", 11'd116, 11'd344, 1'b1, 1'b0, 4'h0);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("hit_confirm", 11'd116, 11'd344, 1'b0, 1'b1, 4'hC);
    tick();
    expect_o("hit_one_pulse", 11'd116, 11'd344, 1'b0, 1'b0, 4'hC);

    // Cooldown: three frames pass and the block is still cooling down, so fire is ignored
    frame(); frame(); frame();
    playerTopLeftY = 11'd40;
    fire = 1'b1; tick(); fire = 1'b0; tick();
    expect_o("fire_in_cooldown", 11'd116, 11'd344, 1'b0, 1'b0, 4'hC);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;

    // Miss: a launch at Y=40 starts at 8, steps to 0, then ends at the top
    fire = 1'b1; tick(); fire = 1'b0;
    expect_o("miss_launch", 11'd116, 11'd8, 1'b1, 1'b0, 4'hC);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("miss_step", 11'd116, 11'd0, 1'b1, 1'b0, 4'hC);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("miss", 11'd116, 11'd0, 1'b0, 1'b0, 4'hC);
    collision = 1'b1; HitEdgeCode = 4'hF; tick(); tick();
    collision = 1'b0; HitEdgeCode = 4'h0;
    frame(); frame(); frame(); frame();
    expect_o("cooldown_collision_ignored", 11'd116, 11'd0, 1'b0, 1'b0, 4'hC);

    // A collision in the same cycle as startOfFrame counts as a hit
    playerTopLeftY = 11'd400;
    fire = 1'b1; tick(); fire = 1'b0;
    expect_o("relaunch", 11'd116, 11'd368, 1'b1, 1'b0, 4'hC);
    collision = 1'b1; HitEdgeCode = 4'h2; startOfFrame = 1'b1; tick();
    collision = 1'b0; HitEdgeCode = 4'h0; startOfFrame = 1'b0;
    expect_o("same_cycle_hit", 11'd116, 11'd368, 1'b0, 1'b1, 4'h2);

    // Fire held from launch through the whole cooldown
    frame(); frame(); frame(); frame();
    fire = 1'b1; tick();
    expect_o("held_launch", 11'd116, 11'd368, 1'b1, 1'b0, 4'h2);
    collision = 1'b1; HitEdgeCode = 4'h1; startOfFrame = 1'b1; tick();
    collision = 1'b0; HitEdgeCode = 4'h0; startOfFrame = 1'b0;
    expect_o("held_hit", 11'd116, 11'd368, 1'b0, 1'b1, 4'h1);
    frame(); frame(); frame();
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("cooldown_end", 11'd116, 11'd368, 1'b0, 1'b0, 4'h1);
    tick();
    expect_o("held_fire", 11'd116, 11'd368, held_vis, 1'b0, 4'h1);

    // Reset asserted mid-flight, with a collision already latched
    fire = 1'b0; tick();
    fire = 1'b1; tick();
    expect_o("flying_before_reset", 11'd116, 11'd368, 1'b1, 1'b0, 4'h1);
    fire = 1'b0;
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("move_before_reset", 11'd116, 11'd360, 1'b1, 1'b0, 4'h1);
    collision = 1'b1; HitEdgeCode = 4'h4; tick();
    collision = 1'b0; HitEdgeCode = 4'h0;
    resetN = 1'b0; startOfFrame = 1'b1; tick();
    expect_o("reset_mid_flight", 11'd0, 11'd0, 1'b0, 1'b0, 4'h0);
    tick();
    expect_o("reset_no_pulse", 11'd0, 11'd0, 1'b0, 1'b0, 4'h0);
    startOfFrame = 1'b0; resetN = 1'b1; tick();
    fire = 1'b1; tick(); fire = 1'b0;
    expect_o("post_reset_launch", 11'd116, 11'd368, 1'b1, 1'b0, 4'h0);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    expect_o("latch_cleared", 11'd116, 11'd360, 1'b1, 1'b0, 4'h0);

    tick(); tick(); tick();
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected snapshots left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
